// File: rtl/uart_trx.sv
// uart_trx -- 8N1 UART transmitter and receiver sharing one clock and reset.
//
// The receive and transmit paths are independent state machines and run
// concurrently. Each serial bit lasts CLKS_PER_BIT clock cycles (legal >= 4).
//
// Optional build macro: UART_RX_SYNC_EN
//   defined   -> i_Rx_Serial passes through a 2-flop synchronizer (reset 1),
//                adding 2 cycles of receive latency
//   undefined -> the receive FSM samples i_Rx_Serial directly
//
// Ports
//   i_Clock      clock, all state changes on its rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_Rx_Serial  receive serial line, idle high
//   o_Rx_DV      one-cycle pulse: a byte was received with a good stop bit
//   o_Rx_Byte    last correctly received byte, held until the next one
//   i_Tx_DV      transmit request strobe, honoured only while idle
//   i_Tx_Byte    byte to transmit, sampled with i_Tx_DV
//   o_Tx_Active  high while a transmit frame is on the line
//   o_Tx_Serial  transmit serial line, idle high
//   o_Tx_Done    one-cycle pulse after the stop bit
module uart_trx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // last count of a full bit period
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // START is entered one cycle after the line was first seen low, so the
  // mid-bit re-sample happens (CLKS_PER_BIT-1)/2 cycles after that edge
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  // ---------------------------------------------------------------- rx line
  logic rx_line;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], i_Rx_Serial};
  end

  assign rx_line = rx_sync_q[1];
`else
  assign rx_line = i_Rx_Serial;
`endif

  // ---------------------------------------------------------------- receiver
  state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_dv_q, rx_dv_d;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_line) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          // high at mid start bit: a glitch, not a frame
          rx_state_d = rx_line ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_line;
          if (rx_idx_q == 3'd7) begin
            rx_idx_d   = '0;
            rx_state_d = S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_CLEANUP;
          // a low stop bit is a framing error: drop the byte silently
          if (rx_line) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_CLEANUP: rx_state_d = S_IDLE;
      default:   rx_state_d = S_IDLE;
    endcase
  end

  assign o_Rx_DV   = rx_dv_q;
  assign o_Rx_Byte = rx_byte_q;

  // ------------------------------------------------------------- transmitter
  state_e          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_ser_q, tx_ser_d;
  logic            tx_act_q, tx_act_d;
  logic            tx_done_q, tx_done_d;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_ser_q   <= 1'b1;
      tx_act_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_data_q  <= tx_data_d;
      tx_ser_q   <= tx_ser_d;
      tx_act_q   <= tx_act_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (i_Tx_DV) begin
          tx_data_d  = i_Tx_Byte;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_idx_d   = '0;
            tx_state_d = S_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_CLEANUP: tx_state_d = S_IDLE;
      default:   tx_state_d = S_IDLE;
    endcase

    // line outputs are registered from the next state so they change
    // together with the state and never glitch
    case (tx_state_d)
      S_START: tx_ser_d = 1'b0;
      S_DATA:  tx_ser_d = tx_data_d[tx_idx_d];
      default: tx_ser_d = 1'b1;
    endcase
    tx_act_d  = (tx_state_d == S_START) || (tx_state_d == S_DATA) ||
                (tx_state_d == S_STOP);
    tx_done_d = (tx_state_d == S_CLEANUP);
  end

  assign o_Tx_Serial = tx_ser_q;
  assign o_Tx_Active = tx_act_q;
  assign o_Tx_Done   = tx_done_q;

endmodule

// File: tb/tb_uart_trx.sv
// Bench for uart_trx. Two instances: dut (4 clocks/bit) carries the transmit
// and most receive traffic, dut16 (16 clocks/bit) receives the 8'h05 frame.
// A frame-level model predicts, per cycle, the transmit line and the cycle at
// which each good receive frame must raise its data-valid pulse.
module tb_uart_trx;

  localparam int C0 = 4;
  localparam int C1 = 16;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       dv0, dv1, act0, act1, ser0, ser1, done0, done1;
  logic [7:0] by0, by1;

  uart_trx #(.CLKS_PER_BIT(C0)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx0),
    .o_Rx_DV(dv0), .o_Rx_Byte(by0),
    .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Active(act0), .o_Tx_Serial(ser0), .o_Tx_Done(done0)
  );

  uart_trx #(.CLKS_PER_BIT(C1)) dut16 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx1),
    .o_Rx_DV(dv1), .o_Rx_Byte(by1),
    .i_Tx_DV(1'b0), .i_Tx_Byte(8'h00),
    .o_Tx_Active(act1), .o_Tx_Serial(ser1), .o_Tx_Done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {int at; logic [7:0] b;} rxe_t;
  rxe_t       q0[$], q1[$];
  logic [7:0] eb0 = 8'h00, eb1 = 8'h00;
  int         tx_start = -100000;
  logic [7:0] tx_mbyte = 8'h00;
  int         dv0_cnt = 0, dv1_cnt = 0, done_cnt = 0;

  // transmitter is busy from the cycle a request is taken until its cleanup
  function automatic bit tx_busy();
    return (cyc - tx_start) <= 10 * C0;
  endfunction

  task automatic model_reset();
    tx_start = -100000;
    q0.delete();
    q1.delete();
    eb0 = 8'h00;
    eb1 = 8'h00;
  endtask

  always @(negedge clk) begin
    int k;
    logic [9:0] fr;
    logic es, ea, ed, edv0, edv1;
    k  = cyc - tx_start;
    fr = {1'b1, tx_mbyte, 1'b0};
    if (k >= 0 && k < 10 * C0) begin
      es = fr[k / C0]; ea = 1'b1; ed = 1'b0;
    end else if (k == 10 * C0) begin
      es = 1'b1; ea = 1'b0; ed = 1'b1;
    end else begin
      es = 1'b1; ea = 1'b0; ed = 1'b0;
    end
    edv0 = 1'b0;
    if (q0.size() > 0 && q0[0].at == cyc) begin
      edv0 = 1'b1; eb0 = q0[0].b; void'(q0.pop_front());
    end
    edv1 = 1'b0;
    if (q1.size() > 0 && q1[0].at == cyc) begin
      edv1 = 1'b1; eb1 = q1[0].b; void'(q1.pop_front());
    end
    chk("tx_serial", ser0, es);
    chk("tx_active", act0, ea);
    chk("tx_done", done0, ed);
    chk("rx_dv", dv0, edv0);
    chk("rx_byte", by0, eb0);
    chk("rx16_dv", dv1, edv1);
    chk("rx16_byte", by1, eb1);
    chk("tx16_idle", {act1, ser1, done1}, 3'b010);
    if (dv0 === 1'b1) dv0_cnt++;
    if (dv1 === 1'b1) dv1_cnt++;
    if (done0 === 1'b1) done_cnt++;
  end

  // ---------------------------------------------------------------- drivers
  // all drivers start and end 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    tx_dv = 1'b1;
    tx_byte = b;
    if (!tx_busy()) begin
      tx_start = cyc + 1;
      tx_mbyte = b;
    end
    idle(1);
    tx_dv = 1'b0;
  endtask

  task automatic rx_send(input int inst, input logic [7:0] b, input logic stop);
    int c, h;
    logic [9:0] fr;
    rxe_t e;
    c  = (inst != 0) ? C1 : C0;
    h  = (c - 1) / 2;
    fr = {stop, b, 1'b0};
    // line seen low at the next edge, mid-start check h cycles later,
    // then 8 data bits and the stop bit, one bit period each
    if (stop) begin
      e.at = cyc + 1 + h + 9 * c + LAT;
      e.b  = b;
      if (inst != 0) q1.push_back(e); else q0.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (inst != 0) rx1 = fr[i]; else rx0 = fr[i];
      idle(c);
    end
    if (inst != 0) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int lit55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int d;
    #2 rst_n = 1'b0;
    idle(2);
    chk("reset_serial", ser0, 1'b1);
    chk("reset_active", act0, 1'b0);
    chk("reset_done", done0, 1'b0);
    chk("reset_dv", dv0, 1'b0);
    chk("reset_byte", by0, 8'h00);
    rst_n = 1'b1;
    idle(3);

    // 8'h55: literal waveform, each bit checked at its middle
    d = done_cnt;
    send_tx(8'h55);
    for (int b = 0; b < 10; b++) begin
      idle(2);
      chk("tx55_bit", ser0, lit55[b]);
      idle(2);
    end
    chk("tx55_done_at_40", done0, 1'b1);
    chk("tx55_active_off", act0, 1'b0);
    idle(1);
    chk("tx55_done_one_cycle", done0, 1'b0);
    chk("tx55_done_count", done_cnt - d, 1);
    idle(5);

    // 8'h05 on both receivers
    rx_send(1, 8'h05, 1'b1);
    idle(4);
    chk("rx16_05_byte", by1, 8'h05);
    chk("rx16_05_pulses", dv1_cnt, 1);
    rx_send(0, 8'h05, 1'b1);
    idle(4);
    chk("rx_05_byte", by0, 8'h05);

    // transmit 8'hAB, then receive 8'hC9
    send_tx(8'hAB);
    idle(45);
    rx_send(0, 8'hC9, 1'b1);
    idle(4);
    chk("rx_C9_byte", by0, 8'hC9);
    chk("rx_C9_pulses", dv0_cnt, 2);

    // transmit and receive at the same time
    fork
      send_tx(8'h3C);
      rx_send(0, 8'h96, 1'b1);
    join
    idle(50);
    chk("rx_96_byte", by0, 8'h96);

    // request while busy is ignored; next request right at idle is taken
    d = done_cnt;
    send_tx(8'h12);
    idle(5);
    send_tx(8'hFF);
    for (int i = 0; i < 100 && tx_busy(); i++) idle(1);
    send_tx(8'h34);
    idle(50);
    chk("tx_ignore_done_count", done_cnt - d, 2);

    // one-cycle glitch on an idle line
    rx0 = 1'b0;
    idle(1);
    rx0 = 1'b1;
    idle(20);
    chk("glitch_byte", by0, 8'h96);
    chk("glitch_pulses", dv0_cnt, 3);

    // framing error: stop bit low
    rx_send(0, 8'h77, 1'b0);
    idle(10);
    chk("frame_err_byte", by0, 8'h96);
    chk("frame_err_pulses", dv0_cnt, 3);

    // reset during the data bits of 8'hA5
    d = done_cnt;
    send_tx(8'hA5);
    idle(12);
    chk("pre_reset_active", act0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_serial", ser0, 1'b1);
    chk("mid_reset_active", act0, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(50);
    chk("mid_reset_no_done", done_cnt - d, 0);
    chk("mid_reset_byte", by0, 8'h00);

    chk("rx_pending_empty", q0.size(), 0);
    chk("rx16_pending_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
